// File: rtl/disp_pkg.sv
// Shared types, segment constants and the digit-to-segment lookup for display_ctrl.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ENCODE  = 2'd2
    } state_t;

    localparam int         BCD_DIGITS = 5;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_MINUS  = 7'b0111111;

    // Active-low patterns, bit0 = segment a ... bit6 = segment g.
    function automatic logic [6:0] bcd2seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, WIDTH cycles after start.
// done rises the cycle after the last shift and holds until the next start.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIDTH-1:0]               din,
    output logic                           done,
    output logic [BCD_DIGITS-1:0][3:0]     bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]        shift;
    logic [4*BCD_DIGITS-1:0] acc;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CW-1:0]           cnt;
    logic                    running;

    // Add 3 to every digit that would exceed 9 after the next doubling.
    always_comb begin
        adj = acc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            shift   <= din;
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            acc   <= {adj[4*BCD_DIGITS-2:0], shift[WIDTH-1]};
            shift <= {shift[WIDTH-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/display_ctrl.sv
// Round-robin arbiter between entry/result sources, BCD conversion and 7-segment encoding.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module display_ctrl
    import disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entryValid,
    input  logic [WIDTH-1:0] entryValue,
    output logic             entryReady,
    input  logic             resultValid,
    input  logic [WIDTH-1:0] resultValue,
    input  logic             resultNeg,
    output logic             resultReady,
    output logic [6:0]       displayBits [3:0],
    output logic             busy,
    output logic             srcSel
);

    state_t                      state;
    logic                        last_res;
    logic                        sign_q;
    logic                        src_q;
    logic                        idle;
    logic                        tie;
    logic                        ent_hs;
    logic                        res_hs;
    logic                        hs;
    logic [WIDTH-1:0]            din;
    logic                        conv_done;
    logic [BCD_DIGITS-1:0][3:0]  bcd;
    logic                        ovf;
    logic [6:0]                  seg_next [3:0];
`ifdef DISP_LZ_BLANK_EN
    logic                        lead;
`endif

    assign idle = (state == IDLE);
    assign tie  = entryValid && resultValid;

    // On a tie the source not granted last time wins; the loser sees ready low.
    assign entryReady  = idle && !(tie && !last_res);
    assign resultReady = idle && !(tie && last_res);
    assign ent_hs      = entryValid && entryReady;
    assign res_hs      = resultValid && resultReady;
    assign hs          = ent_hs || res_hs;
    assign din         = res_hs ? resultValue : entryValue;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (hs),
        .din   (din),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Digit 4 set, or a negative magnitude above 999, cannot fit in four digits.
    always_comb begin
        ovf = (bcd[4] != 4'd0) || (sign_q && (bcd[3] != 4'd0));
        for (int i = 0; i < 4; i++)
            seg_next[i] = bcd2seg(bcd[i]);
`ifdef DISP_LZ_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (bcd[i] == 4'd0))
                seg_next[i] = SEG_BLANK;
            else
                lead = 1'b0;
        end
`endif
        if (sign_q)
            seg_next[3] = SEG_MINUS;
        if (ovf) begin
            for (int i = 0; i < 4; i++)
                seg_next[i] = SEG_MINUS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            srcSel   <= 1'b0;
            last_res <= 1'b0;
            sign_q   <= 1'b0;
            src_q    <= 1'b0;
            for (int i = 0; i < 4; i++)
                displayBits[i] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        sign_q   <= res_hs && resultNeg;
                        src_q    <= res_hs;
                        last_res <= res_hs;
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (conv_done)
                        state <= ENCODE;
                end
                ENCODE: begin
                    for (int i = 0; i < 4; i++)
                        displayBits[i] <= seg_next[i];
                    srcSel <= src_q;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: directed transactions push expected frames, a monitor checks each update.
module tb_display_ctrl;

    localparam int WIDTH = 14;
    localparam int LAT   = WIDTH + 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000, S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111, SM = 7'b0111111;
`ifdef DISP_LZ_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             entryValid, resultValid, resultNeg;
    logic [WIDTH-1:0] entryValue, resultValue;
    logic             entryReady, resultReady, busy, srcSel;
    logic [6:0]       displayBits [3:0];

    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    logic [28:0]      exp_q [$];
    int               lat_q [$];
    logic             prev_busy = 1'b0;
    logic [28:0]      mon_e;
    int               mon_l;

    display_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entryValid  (entryValid),
        .entryValue  (entryValue),
        .entryReady  (entryReady),
        .resultValid (resultValid),
        .resultValue (resultValue),
        .resultNeg   (resultNeg),
        .resultReady (resultReady),
        .displayBits (displayBits),
        .busy        (busy),
        .srcSel      (srcSel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] frame(input logic [6:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [27:0] shown();
        return {displayBits[3], displayBits[2], displayBits[1], displayBits[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every falling edge of busy is one display update.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", {4'h0, shown()}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = lat_q.pop_front();
                    check("display", {4'h0, shown()}, {4'h0, mon_e[27:0]});
                    check("srcSel", {31'h0, srcSel}, {31'h0, mon_e[28]});
                    check("latency", cyc - mon_l, LAT);
                end
            end
            prev_busy <= busy;
        end
    end

    task automatic reset_pulse();
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        check("rst_display", {4'h0, shown()}, {4'h0, frame(SB, SB, SB, SB)});
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ready", {30'h0, entryReady, resultReady}, 32'h3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input bit is_res, input int v, input bit neg, input bit expect_it,
                        input logic [27:0] exp_disp);
        bit got = 1'b0;
        @(negedge clk);
        if (is_res) begin
            resultValid = 1'b1; resultValue = WIDTH'(v); resultNeg = neg;
        end else begin
            entryValid = 1'b1; entryValue = WIDTH'(v);
        end
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if (is_res ? resultReady : entryReady) begin
                if (expect_it) exp_q.push_back({is_res, exp_disp});
                @(posedge clk);
                #1;
                if (expect_it) lat_q.push_back(cyc);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        entryValid = 1'b0; resultValid = 1'b0; resultNeg = 1'b0;
        if (!got) check("handshake_timeout", 32'h0, 32'h1);
        else      check("busy_after_hs", {29'h0, busy, entryReady, resultReady}, 32'h4);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Both sources valid at every grant opportunity: result, entry, result, then the held entry.
    task automatic ties();
        logic [1:0] req_rdy [3] = '{2'b01, 2'b10, 2'b01};
        logic [28:0] win    [3] = '{{1'b1, frame(LZ, LZ, S3, S3)},
                                    {1'b0, frame(LZ, LZ, S1, S1)},
                                    {1'b1, frame(S4, S0, S5, S0)}};
        bit ok;
        @(negedge clk);
        entryValid = 1'b1; entryValue = WIDTH'(11);
        resultValid = 1'b1; resultValue = WIDTH'(33); resultNeg = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                #1;
                if (entryReady || resultReady) ok = 1'b1;
                else @(negedge clk);
            end
            if (!ok) begin
                check("tie_timeout", 32'h0, 32'h1);
                break;
            end
            if (t < 3) begin
                check("tie_ready", {30'h0, entryReady, resultReady}, {30'h0, req_rdy[t]});
                exp_q.push_back(win[t]);
            end else begin
                check("solo_ready", {31'h0, entryReady}, 32'h1);
                exp_q.push_back({1'b0, frame(LZ, LZ, S2, S2)});
            end
            @(posedge clk);
            #1;
            lat_q.push_back(cyc);
            case (t)
                0: resultValue = WIDTH'(4050);
                1: entryValue  = WIDTH'(22);
                2: resultValid = 1'b0;
                default: entryValid = 1'b0;
            endcase
        end
        entryValid = 1'b0; resultValid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        entryValid = 1'b0; entryValue = '0;
        resultValid = 1'b0; resultValue = '0; resultNeg = 1'b0;
        #2;
        reset_pulse();
        check("rst_srcSel", {31'h0, srcSel}, 32'h0);

        send(1'b0, 42,    1'b0, 1'b1, frame(LZ, LZ, S4, S2));
        send(1'b1, 9999,  1'b0, 1'b1, frame(S9, S9, S9, S9));
        send(1'b1, 10000, 1'b0, 1'b1, frame(SM, SM, SM, SM));
        send(1'b1, 7,     1'b1, 1'b1, frame(SM, LZ, LZ, S7));
        send(1'b1, 1000,  1'b1, 1'b1, frame(SM, SM, SM, SM));
        send(1'b0, 0,     1'b0, 1'b1, frame(LZ, LZ, LZ, S0));
        send(1'b1, 999,   1'b1, 1'b1, frame(SM, S9, S9, S9));
        wait_drain();

        @(negedge clk);
        #2;
        reset_pulse();
        ties();
        wait_drain();

        // Abort a conversion of 1234 with a reset pulse five cycles in.
        send(1'b0, 1234, 1'b0, 1'b0, frame(SB, SB, SB, SB));
        repeat (4) @(posedge clk);
        #2;
        reset_pulse();
        repeat (30) @(negedge clk);
        check("abort_no_update", {4'h0, shown()}, {4'h0, frame(SB, SB, SB, SB)});
        check("abort_idle", {29'h0, busy, entryReady, resultReady}, 32'h3);

        send(1'b0, 5, 1'b0, 1'b1, frame(LZ, LZ, LZ, S5));
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Display controller that sits between the calculator datapath and `seg_driver`. It arbitrates between two value sources, operand entry and computed result, using valid/ready handshakes. Each accepted value is converted from binary to BCD over several cycles. The block then encodes four 7-segment digit patterns, with sign, overflow and leading-zero handling, and drives them into `seg_driver`'s `displayBits` input.

## Interface
- `WIDTH`, default 14: binary value width; legal range 14..16.
- `clk` in, 1: system clock. The whole block uses this one clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `entryValid` in, 1: an operand-entry value is offered.
- `entryValue` in, WIDTH: operand-entry value, unsigned.
- `entryReady` out, 1: the entry source may hand off this cycle.
- `resultValid` in, 1: a result value is offered.
- `resultValue` in, WIDTH: result magnitude.
- `resultNeg` in, 1: the result is negative.
- `resultReady` out, 1: the result source may hand off this cycle.
- `displayBits` out, 7 bits × [3:0] unpacked: segment patterns.
  - Active-low; bit0 = a … bit6 = g.
  - Index 0 is the rightmost digit.
- `busy` out, 1: a conversion is in progress.
- `srcSel` out, 1: source of the currently displayed value; 0 = entry, 1 = result.

## Operation
- FSM states: IDLE → CONVERT → ENCODE → IDLE.
- In IDLE, `entryReady` = `resultReady` = 1.
- A handshake is `valid && ready` sampled at a clock edge.
  - On a handshake the block captures the value, the sign, and which source was granted, then moves to CONVERT.
  - Entry values always have sign 0.
- Arbitration is round-robin.
  - If both sources are valid in the same cycle, the source not granted last time wins; the loser's ready is 0 in that cycle.
  - After reset, the last grant is `entry`, so `result` wins the first tie.
- CONVERT: iterative double-dabble, one input bit per cycle, WIDTH cycles, producing 5 BCD digits.
- ENCODE is one cycle. Rules are applied in this order:
  1. Overflow: if BCD digit 4 is non-zero, or the sign is set and the magnitude is greater than 999, all four digits show minus (7'b0111111).
  2. Otherwise each digit uses the 0–9 lookup: '0' = 7'b1000000, '2' = 7'b0100100, '4' = 7'b0011001, '7' = 7'b1111000, '9' = 7'b0010000.
  3. If the sign is set, digit 3 is forced to minus.
  4. Leading-zero handling follows Configuration.
- At the end of ENCODE, `displayBits` and `srcSel` are registered and the FSM returns to IDLE.
- `displayBits` holds its value between updates. `seg_driver` may sample it at any time.

## Timing
- Reset values, applied asynchronously:
  - State = IDLE.
  - `displayBits` = 7'b1111111 on all four digits (blank).
  - `srcSel` = 0, `busy` = 0, last grant = entry.
  - Readies are 1, because the FSM is in IDLE.
- Handshake at edge T:
  - `busy` = 1 and both readies = 0 from T through T+WIDTH+1.
  - `displayBits` updates at edge T+WIDTH+2, when `busy` drops and the readies rise.
  - The next handshake is possible at edge T+WIDTH+3 at the earliest.
- Valid without ready: the source must hold valid and value stable until it sees ready. The block drops nothing while ready is 0.
- Reset asserted in CONVERT or ENCODE: the conversion aborts and the display blanks. No stale update occurs after reset is released.
- Input value 0 displays '0' on digit 0 in every configuration.

## Configuration
- Macro: `DISP_LZ_BLANK_EN`.
- Defined:
  - Leading zero digits are blanked (7'b1111111), except digit 0, which is never blanked.
  - For a negative value, minus sits on digit 3 and the blank digits lie between it and the magnitude.
- Undefined: all four digits are always shown, e.g. "0042", or "-042" for a negative value.
- Overflow display is unaffected by the macro.

## Structure
- Shared package `disp_pkg` holds:
  - The FSM state enum.
  - `SEG_BLANK` and `SEG_MINUS` constants.
  - A `bcd2seg` function that maps 0–9 to active-low patterns.
- One sub-module, `bin2bcd_seq`:
  - Interface: start, WIDTH-bit input, done, 5×4-bit BCD output.
  - Owns the shift/add-3 iteration counter.
- `display_ctrl` itself keeps the FSM, the arbiter, the capture registers and the encoder.

## Test plan
- Reset: assert `rst_n` = 0 mid-frame → all `displayBits` = 7'h7F, `busy` = 0, both readies = 1.
- Entry 42 with `DISP_LZ_BLANK_EN` → at T+16, `displayBits[3:0]` = {7F, 7F, 0011001, 0100100} and `srcSel` = 0. Without the macro, digits 3 and 2 show 1000000.
- Results 9999, then 10000 (`resultNeg` = 0) → first 0010000 on all four digits, then 0111111 on all four digits. `srcSel` = 1 in both cases.
- Result 7 with `resultNeg` = 1 → {0111111, 7F, 7F, 1111000}. Result 1000 with `resultNeg` = 1 → all minus.
- Both valid in the same cycle, repeated three times → grant order result, entry, result. The losing source's ready is 0 in the tie cycle and its value is displayed next.
- Reset pulse at T+5 of a conversion of 1234 → display stays blank after release with no later update. A new entry of 5 then displays correctly.
